// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the instruction-fetch unit, its control FSM and the
// instruction memory. The fetch unit uses the master modport because it
// originates the memory reads. The surrounding control/memory side uses
// the slave modport.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 64
);
    // control side
    logic              fetch_req;
    logic [ADDR_W-1:0] pc_in;
    logic              flush;
    logic              fault_clr;
    // memory side
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    // results towards control
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              busy;
    logic              fault;
    logic              fault_cause;

    modport master (
        input  fetch_req, pc_in, flush, fault_clr, mem_rdata, mem_ready,
        output mem_addr, mem_rd, instr, instr_pc, instr_valid, busy,
               fault, fault_cause
    );

    modport slave (
        output fetch_req, pc_in, flush, fault_clr, mem_rdata, mem_ready,
        input  mem_addr, mem_rd, instr, instr_pc, instr_valid, busy,
               fault, fault_cause
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction-fetch stage. Reads one 32-bit word over a
// variable-latency ready handshake, loads it into IR with its address and
// pulses instr_valid for one cycle. Handles branch flush, misaligned fetch
// addresses and memory-response timeout (latched fault until fault_clr).
module instr_fetch_unit #(
    parameter int          ADDR_W      = 64,
    parameter int          TIMEOUT     = 16,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);

    // A zero TIMEOUT still needs a 1-bit counter so the declarations stay legal.
    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_fault;
    logic              r_fault_cause;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic              w_load_ir;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_cause_next;

    // Next-state decode plus the per-state datapath enables.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load_ir    = 1'b0;
        w_cnt_next   = r_cnt;
        w_cause_next = r_fault_cause;
        case (r_state)
            S_IDLE: begin
                if (bus.fetch_req) begin
                    if (bus.pc_in[1:0] != 2'b00) begin
                        // Misaligned: fault straight away, memory never sees it.
                        w_next_state = S_FAULT;
                        w_cause_next = 1'b0;
                    end else begin
                        w_next_state = S_REQ;
                        w_accept     = 1'b1;
                        w_cnt_next   = '0;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.flush) begin
                    // Flush beats a same-cycle response; that data is dropped.
                    w_next_state = S_IDLE;
                end else if (bus.mem_ready) begin
                    w_next_state = S_DONE;
                    w_load_ir    = 1'b1;
                end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
                    w_next_state = S_FAULT;
                    w_cause_next = 1'b1;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end else begin
                    w_cnt_next = r_cnt;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            S_FAULT: begin
                if (bus.fault_clr) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_FAULT;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register and all registered datapath/outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_mem_addr    <= '0;
            r_mem_rd      <= 1'b0;
            r_instr       <= RESET_INSTR;
            r_instr_pc    <= '0;
            r_fault       <= 1'b0;
            r_fault_cause <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_next_state;
            // Read strobe is a function of the state being entered, so it
            // only changes on state transitions.
            r_mem_rd      <= (w_next_state == S_REQ);
            r_fault       <= (w_next_state == S_FAULT);
            r_fault_cause <= w_cause_next;
            r_cnt         <= w_cnt_next;
            if (w_accept) begin
                r_mem_addr <= bus.pc_in;
            end
            if (w_load_ir) begin
                r_instr    <= bus.mem_rdata;
                r_instr_pc <= r_mem_addr;
            end
        end
    end

    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_rd      = r_mem_rd;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = (r_state == S_DONE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.fault       = r_fault;
    assign bus.fault_cause = r_fault_cause;

endmodule
